// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM stage.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [2:0] a,
    input logic       wide
  );
    logic m;
    m = 1'b0;
    unique case (size)
      SZ_B: m = 1'b0;
      SZ_H: m = a[0];
      SZ_W: m = |a[1:0];
      SZ_D: m = ~wide | (|a);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] be_mask(
    input logic [1:0] size
  );
    logic [7:0] m;
    m = 8'h00;
    unique case (size)
      SZ_B: m = 8'h01;
      SZ_H: m = 8'h03;
      SZ_W: m = 8'h0f;
      SZ_D: m = 8'hff;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_hs_lane.sv
// Byte-lane steering: store enables/replication, load extract/extend.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DW = 32,
  parameter int LW = $clog2(DW / 8)
) (
  input  logic [1:0]      size,
  input  logic [LW-1:0]   lane,
  input  logic            uns,
  input  logic [DW-1:0]   wdata,
  input  logic [DW-1:0]   rdata,
  output logic [DW/8-1:0] be,
  output logic [DW-1:0]   wrep,
  output logic [DW-1:0]   ldata
);

  localparam int BW = DW / 8;

  logic [DW-1:0] sh;

  always_comb begin
    sh    = rdata >> {lane, 3'b000};
    be    = BW'(be_mask(size)) << lane;
    wrep  = wdata;
    ldata = sh;
    unique case (size)
      SZ_B: begin
        wrep  = {(DW/8){wdata[7:0]}};
        ldata = uns ? DW'(sh[7:0])
                    : {{(DW-8){sh[7]}}, sh[7:0]};
      end
      SZ_H: begin
        wrep  = {(DW/16){wdata[15:0]}};
        ldata = uns ? DW'(sh[15:0])
                    : {{(DW-16){sh[15]}}, sh[15:0]};
      end
      SZ_W: begin
        wrep  = {(DW/32){wdata[31:0]}};
        if (DW > 32)
          ldata = uns ? DW'(sh[31:0])
                      : {{(DW-32){sh[31]}}, sh[31:0]};
        else
          ldata = sh;
      end
      default: begin
        wrep  = wdata;
        ldata = sh;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM stage with handshaked data port, timeout, MEM/WB register,
// branch resolve and forwarding sources.
module mem_stage_hs
  import mem_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int RW      = 5,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_reg_write,
  input  logic            ex_mem_to_reg,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [1:0]      ex_size,
  input  logic            ex_unsigned,
  input  logic [RW-1:0]   ex_rd,
  input  logic [AW-1:0]   ex_alu_result,
  input  logic [DW-1:0]   ex_wdata,
  input  logic            ex_branch,
  input  logic            ex_zero,
  input  logic [AW-1:0]   ex_branch_tgt,
  output logic            dm_req,
  output logic            dm_we,
  output logic [AW-1:0]   dm_addr,
  output logic [DW/8-1:0] dm_be,
  output logic [DW-1:0]   dm_wdata,
  input  logic            dm_gnt,
  input  logic            dm_rvalid,
  input  logic [DW-1:0]   dm_rdata,
  output logic            stall,
  output logic            br_taken,
  output logic [AW-1:0]   br_target,
  output logic            wb_valid,
  output logic            wb_reg_write,
  output logic            wb_mem_to_reg,
  output logic [RW-1:0]   wb_rd,
  output logic [AW-1:0]   wb_alu_result,
  output logic [DW-1:0]   wb_rdata,
  output logic            wb_misalign,
  output logic            wb_bus_err,
  output logic            fwd_mem_we,
  output logic [RW-1:0]   fwd_mem_rd,
  output logic [DW-1:0]   fwd_mem_data,
  output logic            fwd_wb_we,
  output logic [RW-1:0]   fwd_wb_rd,
  output logic [DW-1:0]   fwd_wb_data
);

  localparam int LW = $clog2(DW / 8);

  state_t        state;
  logic [7:0]    cnt;
  logic          mem_op, mis, go, is_ld, tmo;
  logic          done, berr;
  logic [DW-1:0] ld_data;

  assign mem_op = ex_valid & (ex_mem_read | ex_mem_write);
  assign is_ld  = ex_mem_read;
  assign mis    = mem_op &
                  misaligned(ex_size, ex_alu_result[2:0], DW == 64);
  assign go     = mem_op & ~mis;
  assign tmo    = cnt == 8'(TIMEOUT - 1);

  always_comb begin
    dm_req = 1'b0;
    done   = 1'b0;
    berr   = 1'b0;
    unique case (state)
      S_IDLE: begin
        dm_req = go;
        done   = go & dm_gnt & ~is_ld;
      end
      S_REQ: begin
        if (tmo) begin
          done = 1'b1;
          berr = 1'b1;
        end else begin
          dm_req = 1'b1;
          done   = dm_gnt & ~is_ld;
        end
      end
      S_RESP: begin
        if (dm_rvalid) begin
          done = 1'b1;
        end else if (tmo) begin
          done = 1'b1;
          berr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign stall   = go & ~done;
  assign dm_we   = ex_mem_write & ~ex_mem_read;
  assign dm_addr = {ex_alu_result[AW-1:LW], {LW{1'b0}}};

  mem_lane_align #(.DW(DW)) u_lane (
    .size  (ex_size),
    .lane  (ex_alu_result[LW-1:0]),
    .uns   (ex_unsigned),
    .wdata (ex_wdata),
    .rdata (dm_rdata),
    .be    (dm_be),
    .wrep  (dm_wdata),
    .ldata (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_rd         <= '0;
      wb_alu_result <= '0;
      wb_rdata      <= '0;
      wb_misalign   <= 1'b0;
      wb_bus_err    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (stall) begin
            state <= dm_gnt ? S_RESP : S_REQ;
            cnt   <= '0;
          end
        end
        S_REQ: begin
          if (done) begin
            state <= S_IDLE;
          end else if (dm_gnt) begin
            state <= S_RESP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (done) state <= S_IDLE;
          else      cnt   <= cnt + 8'd1;
        end
        default: state <= S_IDLE;
      endcase
      // a stalled cycle pushes a bubble; payload fields are don't-care
      if (!stall) begin
        wb_valid      <= ex_valid;
        wb_reg_write  <= ex_valid & ex_reg_write & ~mis & ~berr;
        wb_mem_to_reg <= ex_mem_to_reg;
        wb_rd         <= ex_rd;
        wb_alu_result <= ex_alu_result;
        wb_rdata      <= berr ? '0 : ld_data;
        wb_misalign   <= mis;
        wb_bus_err    <= berr;
      end else begin
        wb_valid <= 1'b0;
      end
    end
  end

  assign br_taken     = ex_valid & ex_branch & ex_zero;
  assign br_target    = ex_branch_tgt;
  assign fwd_mem_we   = ex_valid & ex_reg_write & ~ex_mem_to_reg;
  assign fwd_mem_rd   = ex_rd;
  assign fwd_mem_data = DW'(ex_alu_result);
  assign fwd_wb_we    = wb_valid & wb_reg_write;
  assign fwd_wb_rd    = wb_rd;
  assign fwd_wb_data  = wb_mem_to_reg ? wb_rdata
                                      : DW'(wb_alu_result);

endmodule
